// File: rtl/fg_output_sequencer.sv
// Output sequencing controller for the limiter stage. It accepts enable/select/offset
// requests and mutes the output around a source change so the switch is glitch-free.
module fg_output_sequencer #(
  parameter int unsigned BITWIDTH      = 16,
  parameter int unsigned DATA_COUNT    = 3,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                          clk_i,
  input  logic                          nrst_i,
  input  logic                          sample_strobe_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic                          cfg_enable_i,
  input  logic [$clog2(DATA_COUNT)-1:0] cfg_select_i,
  input  logic [BITWIDTH-1:0]           cfg_offset_i,
  output logic                          cfg_err_o,
  output logic                          enable_o,
  output logic [$clog2(DATA_COUNT)-1:0] select_o,
  output logic [BITWIDTH-1:0]           offset_o,
  output logic                          busy_o
);

  localparam int unsigned SW = $clog2(DATA_COUNT);
  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_MUTE = 2'd2;
  localparam logic [1:0] S_LOAD = 2'd3;

  logic [1:0]          r_state, w_state;
  logic                r_enable, w_enable;
  logic [SW-1:0]       r_select, w_select;
  logic [BITWIDTH-1:0] r_offset, w_offset;
  logic                r_pend_en, w_pend_en;
  logic [SW-1:0]       r_pend_sel, w_pend_sel;
  logic [BITWIDTH-1:0] r_pend_off, w_pend_off;
  logic [CW-1:0]       r_cnt, w_cnt;
  logic                r_err, w_err;
  logic                r_ready, w_ready;
  logic                r_busy, w_busy;
  logic                w_accept;
  logic                w_bad_sel;

  assign w_accept  = cfg_valid_i && r_ready;
  assign w_bad_sel = 32'(cfg_select_i) >= DATA_COUNT;

  // Next-state and next-output logic
  always_comb begin
    w_state    = r_state;
    w_enable   = r_enable;
    w_select   = r_select;
    w_offset   = r_offset;
    w_pend_en  = r_pend_en;
    w_pend_sel = r_pend_sel;
    w_pend_off = r_pend_off;
    w_cnt      = r_cnt;
    w_err      = 1'b0;

    case (r_state)
      S_OFF, S_RUN: begin
        if (w_accept) begin
          if (w_bad_sel) begin
            w_err = 1'b1;
          end else if (!cfg_enable_i) begin
            w_enable = 1'b0;
            w_select = cfg_select_i;
            w_offset = cfg_offset_i;
            w_state  = S_OFF;
          end else begin
            w_pend_en  = 1'b1;
            w_pend_sel = cfg_select_i;
            w_pend_off = cfg_offset_i;
            // A live output switching source must be muted and settled first
            if (r_state == S_RUN && cfg_select_i != r_select) begin
              w_enable = 1'b0;
              w_cnt    = CW'(SETTLE_CYCLES);
              w_state  = S_MUTE;
            end else begin
              w_state = S_LOAD;
            end
          end
        end
      end
      S_MUTE: begin
        if (sample_strobe_i) begin
          if (r_cnt == CW'(1)) begin
            w_cnt   = '0;
            w_state = S_LOAD;
          end else begin
            w_cnt = r_cnt - CW'(1);
          end
        end
      end
      S_LOAD: begin
        if (sample_strobe_i) begin
          w_enable = r_pend_en;
          w_select = r_pend_sel;
          w_offset = r_pend_off;
          w_state  = S_RUN;
        end
      end
      default: w_state = S_OFF;
    endcase

    w_ready = (w_state == S_OFF) || (w_state == S_RUN);
    w_busy  = !w_ready;
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      r_state    <= S_OFF;
      r_enable   <= 1'b0;
      r_select   <= '0;
      r_offset   <= '0;
      r_pend_en  <= 1'b0;
      r_pend_sel <= '0;
      r_pend_off <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_enable   <= w_enable;
      r_select   <= w_select;
      r_offset   <= w_offset;
      r_pend_en  <= w_pend_en;
      r_pend_sel <= w_pend_sel;
      r_pend_off <= w_pend_off;
      r_cnt      <= w_cnt;
      r_err      <= w_err;
      r_ready    <= w_ready;
      r_busy     <= w_busy;
    end
  end

  assign cfg_ready_o = r_ready;
  assign cfg_err_o   = r_err;
  assign enable_o    = r_enable;
  assign select_o    = r_select;
  assign offset_o    = r_offset;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_fg_output_sequencer.sv
// Bench for fg_output_sequencer: directed scenarios followed by random traffic, all
// checked against a model that only counts the strobes still owed before the next config is applied.
module tb_fg_output_sequencer;

  localparam int unsigned BW     = 16;
  localparam int unsigned DC     = 3;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned SW     = $clog2(DC);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          strobe = 1'b0;
  logic          valid = 1'b0;
  logic          ready;
  logic          en_in = 1'b0;
  logic [SW-1:0] sel_in = '0;
  logic [BW-1:0] off_in = '0;
  logic          err;
  logic          en_out;
  logic [SW-1:0] sel_out;
  logic [BW-1:0] off_out;
  logic          busy;

  int n_err = 0;
  int n_chk = 0;

  // Reference state: live output, plus strobes still owed before the pending config lands
  logic          m_en, m_err;
  logic [SW-1:0] m_sel, m_pend_sel;
  logic [BW-1:0] m_off, m_pend_off;
  int            m_rem;

  fg_output_sequencer #(.BITWIDTH(BW), .DATA_COUNT(DC), .SETTLE_CYCLES(SETTLE)) dut (
    .clk_i(clk), .nrst_i(nrst), .sample_strobe_i(strobe),
    .cfg_valid_i(valid), .cfg_ready_o(ready), .cfg_enable_i(en_in),
    .cfg_select_i(sel_in), .cfg_offset_i(off_in), .cfg_err_o(err),
    .enable_o(en_out), .select_o(sel_out), .offset_o(off_out), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit acc;
    if (!nrst) begin
      m_en = 0; m_sel = '0; m_off = '0; m_pend_sel = '0; m_pend_off = '0;
      m_err = 0; m_rem = 0;
    end else begin
      acc   = valid && (m_rem == 0);
      m_err = acc && (32'(sel_in) >= DC);
      if (acc && !m_err) begin
        if (!en_in) begin
          m_en = 0; m_sel = sel_in; m_off = off_in;
        end else begin
          m_pend_sel = sel_in; m_pend_off = off_in;
          if (m_en && sel_in != m_sel) begin
            m_en  = 0;
            m_rem = SETTLE + 1;
          end else begin
            m_rem = 1;
          end
        end
      end else if (m_rem > 0 && strobe) begin
        m_rem--;
        if (m_rem == 0) begin
          m_en = 1; m_sel = m_pend_sel; m_off = m_pend_off;
        end
      end
    end
  endtask

  task automatic step(input logic rst_n, input logic stb, input logic vld,
                      input logic en, input logic [SW-1:0] sel, input logic [BW-1:0] off);
    nrst = rst_n; strobe = stb; valid = vld; en_in = en; sel_in = sel; off_in = off;
    model_edge();
    @(posedge clk);
    #1;
    chk("enable", 32'(en_out), 32'(m_en));
    chk("select", 32'(sel_out), 32'(m_sel));
    chk("offset", 32'(off_out), 32'(m_off));
    chk("ready", 32'(ready), 32'(m_rem == 0));
    chk("busy", 32'(busy), 32'(m_rem != 0));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, '0, '0);
  endtask

  task automatic strobe1();
    step(1, 1, 0, 0, '0, '0);
  endtask

  initial begin
    // Reset
    step(0, 0, 0, 0, '0, '0);
    step(0, 1, 1, 1, 2'd1, 16'h1234);
    chk("rst_ready_const", 32'(ready), 32'd1);
    chk("rst_enable_const", 32'(en_out), 32'd0);

    // Enable from OFF, strobe three cycles later
    step(1, 0, 1, 1, 2'd2, 16'h0100);
    idle(2);
    strobe1();
    chk("first_en", 32'(en_out), 32'd1);
    chk("first_sel", 32'(sel_out), 32'd2);
    chk("first_off", 32'(off_out), 32'h0100);

    // Source change 2 -> 0: muted for exactly SETTLE+1 strobes
    step(1, 0, 1, 1, 2'd0, 16'hFF00);
    chk("mute_en", 32'(en_out), 32'd0);
    chk("mute_busy", 32'(busy), 32'd1);
    for (int s = 0; s < SETTLE + 1; s++) begin
      chk("mute_held", 32'(en_out), 32'd0);
      idle(2);
      strobe1();
    end
    chk("switch_en", 32'(en_out), 32'd1);
    chk("switch_sel", 32'(sel_out), 32'd0);

    // Offset-only change never drops enable
    step(1, 0, 1, 1, 2'd0, 16'h0200);
    chk("offonly_en", 32'(en_out), 32'd1);
    idle(1);
    strobe1();
    chk("offonly_off", 32'(off_out), 32'h0200);

    // Out-of-range select is rejected
    step(1, 1, 1, 1, 2'd3, 16'hDEAD);
    chk("bad_err", 32'(err), 32'd1);
    idle(1);
    chk("bad_err_once", 32'(err), 32'd0);

    // Disable is immediate
    step(1, 0, 1, 0, 2'd1, 16'h0055);
    chk("dis_en", 32'(en_out), 32'd0);
    chk("dis_ready", 32'(ready), 32'd1);

    // Enable, then start a change with strobe held high, reset after two strobes in mute
    step(1, 0, 1, 1, 2'd1, 16'h0777);
    strobe1();
    step(1, 0, 1, 1, 2'd2, 16'h0888);
    strobe1();
    strobe1();
    step(0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 6; i++) strobe1();
    chk("rst_abort_en", 32'(en_out), 32'd0);

    // Continuous strobe through a full source change, requester holding valid while busy
    step(1, 0, 1, 1, 2'd0, 16'h0011);
    strobe1();
    step(1, 1, 1, 1, 2'd1, 16'h0022);
    for (int i = 0; i < SETTLE + 3; i++) step(1, 1, 1, 1, 2'd2, 16'h0033);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 80) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
           ($urandom % 4) != 0, SW'($urandom % 4), BW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fg_output_sequencer.md
# fg_output_sequencer

Sequencing controller for the function generator's output limiter stage. Accepts output configuration (enable, source select, offset) over a valid/ready handshake and drives the limiter's enable, select and offset inputs. A source change on a live output is made glitch-free: the output is muted, held for a programmable number of sample periods, and then re-enabled with the new source and offset. Sits between the register/control interface and the limiter, in the sample-clock domain.

## Interface
- BITWIDTH, 16, sample and offset width
- DATA_COUNT, 3, number of selectable waveform sources
- SETTLE_CYCLES, 4, muted sample strobes before a new source is applied; must be ≥ 1
- clk_i  in  1  system clock
- nrst_i  in  1  reset; one clock, synchronous, active-low
- sample_strobe_i  in  1  one-cycle pulse per output sample period
- cfg_valid_i  in  1  configuration request valid
- cfg_ready_o  out  1  controller can accept a configuration
- cfg_enable_i  in  1  requested output enable
- cfg_select_i  in  $clog2(DATA_COUNT)  requested source index
- cfg_offset_i  in  BITWIDTH  requested signed offset
- cfg_err_o  out  1  one-cycle pulse: request rejected (select out of range)
- enable_o  out  1  to limiter enable
- select_o  out  $clog2(DATA_COUNT)  to limiter select
- offset_o  out  BITWIDTH  to limiter offset, signed
- busy_o  out  1  high while a reconfiguration is in progress

## Operation
- States: OFF, RUN, MUTE, LOAD. Pending registers hold enable, select and offset.
- A request is accepted when cfg_valid_i && cfg_ready_o. cfg_ready_o = 1 only in OFF and RUN. busy_o = 1 in MUTE and LOAD.
- Range check: a request is invalid when cfg_select_i ≥ DATA_COUNT.
  - An invalid request is still accepted (handshake completes).
  - cfg_err_o pulses the cycle after acceptance.
  - State, pending registers and outputs are unchanged.
- OFF, valid request with enable = 1: latch pending, go to LOAD. No mute is needed because the output is already off.
- OFF, valid request with enable = 0: select_o and offset_o update the next cycle; stay in OFF.
- RUN, valid request with enable = 0: next cycle enable_o = 0, select_o and offset_o take the request values, state goes to OFF. Disable is immediate and does not wait for a strobe.
- RUN, valid request with enable = 1 and select equal to select_o (offset-only change): latch pending, go to LOAD with no mute.
- RUN, valid request with enable = 1 and a different select: latch pending. Next cycle enable_o = 0 and the settle counter loads SETTLE_CYCLES; go to MUTE.
- MUTE: decrement the counter on each sample_strobe_i. A strobe seen with counter == 1 moves to LOAD.
- LOAD: wait for sample_strobe_i. On the strobe, register enable_o = 1 and select_o/offset_o = pending values, then go to RUN. A strobe arriving in the same cycle as LOAD entry is not counted.
- Counter width: $clog2(SETTLE_CYCLES+1). It never wraps, and it is unused outside MUTE.
- offset_o is passed through unmodified. Saturation is not this block's job.

## Timing
- Reset (nrst_i low at a clk_i edge) gives:
  - state OFF
  - enable_o = 0, select_o = 0, offset_o = 0
  - cfg_ready_o = 1, cfg_err_o = 0, busy_o = 0
  - counter = 0, pending registers = 0
- Reset mid-MUTE or mid-LOAD aborts the reconfiguration, and the pending config is discarded.
- All outputs are registered. enable_o, select_o and offset_o change only on a clk_i edge.
- Source-change latency from accept: enable_o falls at accept+1. It rises at the edge after the strobe that follows the SETTLE_CYCLES-th counted strobe. Minimum is SETTLE_CYCLES+1 strobe periods.
- Offset-only latency: new offset takes effect at the clk_i edge after the first strobe following accept+1.
- enable_o never rises in the same cycle select_o changes while in RUN. select_o changes only while enable_o = 0, or at the LOAD strobe edge (the output was muted throughout).
- cfg_valid_i while busy_o = 1 is not accepted. The requester must hold it, and it is taken in the cycle RUN is re-entered.
- sample_strobe_i held high continuously counts one strobe per cycle.

## Test plan
- Reset, then cfg(enable=1, select=2, offset=0x0100), then strobe 3 cycles later -> enable_o=1, select_o=2, offset_o=0x0100 at the edge after the strobe; cfg_err_o stays 0.
- From RUN with select 2: cfg(enable=1, select=0, offset=0xFF00), SETTLE_CYCLES=4 -> enable_o=0 at accept+1, busy_o=1; exactly 5 strobes later enable_o=1 and select_o=0; enable_o stays low for the whole interval.
- From RUN: cfg(enable=1, select=2, offset=0x0200), same select -> enable_o never drops; offset_o=0x0200 after the next strobe.
- cfg(select=3) with DATA_COUNT=3 -> cfg_err_o pulses once; enable_o, select_o and offset_o are unchanged.
- From RUN: cfg(enable=0) -> enable_o=0 at accept+1 with no strobe needed; state returns to OFF and cfg_ready_o=1.
- nrst_i low for one cycle during MUTE after 2 strobes -> all outputs reach reset values; a subsequent strobe does not re-enable the output.
